// File: rtl/mem_access_unit_if.sv
// Memory-side bus of mem_access_unit.
//   master (the access unit): drives o_mem_req, o_mem_we, o_mem_addr,
//                             o_mem_wdata, o_mem_be; samples i_mem_ack, i_mem_rdata
//   slave  (the memory)     : the reverse
// Handshake: a request is outstanding while o_mem_req=1; the address,
// write strobe, byte enables and write data stay constant until the
// memory raises i_mem_ack for one sampling edge. i_mem_rdata is only
// meaningful in a cycle where i_mem_ack=1.
interface mem_access_unit_if #(
  parameter int NB = 32
);
  logic          o_mem_req;
  logic          o_mem_we;
  logic [NB-1:0] o_mem_addr;
  logic [NB-1:0] o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic          i_mem_ack;
  logic [NB-1:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage. Accepts one byte/half/word access
// per IDLE cycle when i_step=1, issues it on the memory bus, stalls the
// pipeline until acknowledge, and returns extended load data.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_step                    pipeline advance enable
//   i_mem_read, i_mem_write   load / store request
//   i_signed                  sign-extend loads
//   i_word_size               3'b001 byte, 3'b010 half, 3'b100 word
//   i_alu_result, i_data_b    byte address, store data
//   mem                       memory bus (master side)
//   o_stall                   hold pipeline while a request is outstanding
//   o_load_data               extended load result (0 after a timeout)
//   o_load_valid              one-cycle pulse when a load completes
//   o_access_err              one-cycle pulse on an illegal access
//   o_timeout                 one-cycle pulse when the memory never acked
//   o_dbg_state               current FSM state (0 IDLE, 1 REQ, 2 DONE)
module mem_access_unit #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_TIMEOUT   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_step,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic                    i_signed,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic [NB-1:0]           i_alu_result,
  input  logic [NB-1:0]           i_data_b,
  mem_access_unit_if.master       mem,
  output logic                    o_stall,
  output logic [NB-1:0]           o_load_data,
  output logic                    o_load_valid,
  output logic                    o_access_err,
  output logic                    o_timeout,
  output logic [1:0]              o_dbg_state
);

  localparam logic [NB_SIZE_TYPE-1:0] SZ_BYTE = NB_SIZE_TYPE'(1);
  localparam logic [NB_SIZE_TYPE-1:0] SZ_HALF = NB_SIZE_TYPE'(2);
  localparam logic [NB_SIZE_TYPE-1:0] SZ_WORD = NB_SIZE_TYPE'(4);

  localparam int NB_CNT = (NB_TIMEOUT > 2) ? $clog2(NB_TIMEOUT) : 1;
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(NB_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_d;

  // Latched access
  logic [NB-1:0]     addr_q;
  logic [1:0]        off_q;
  logic [3:0]        be_q;
  logic [NB-1:0]     wdata_q;
  logic              we_q;
  logic              signed_q;
  logic              byte_q;
  logic              half_q;
  logic [NB_CNT-1:0] cnt_q;
  logic [NB-1:0]     load_data_q;
  logic              access_err_q;
  logic              timeout_q;

  // Request decode on the incoming EX/MEM signals
  logic          is_byte, is_half, is_word;
  logic          is_access, is_legal;
  logic [3:0]    be_in;
  logic [NB-1:0] wdata_in;

  assign is_byte   = (i_word_size == SZ_BYTE);
  assign is_half   = (i_word_size == SZ_HALF);
  assign is_word   = (i_word_size == SZ_WORD);
  assign is_access = i_mem_read | i_mem_write;
  assign is_legal  = (i_mem_read ^ i_mem_write) &
                     (is_byte |
                      (is_half & ~i_alu_result[0]) |
                      (is_word & (i_alu_result[1:0] == 2'b00)));

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = i_data_b;
    if (is_byte) begin
      be_in    = 4'b0001 << i_alu_result[1:0];
      wdata_in = {(NB/8){i_data_b[7:0]}};
    end else if (is_half) begin
      be_in    = i_alu_result[1] ? 4'b1100 : 4'b0011;
      wdata_in = {(NB/16){i_data_b[15:0]}};
    end
  end

  // FSM control
  logic accept, reject, ack_done, expire;

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    reject   = 1'b0;
    ack_done = 1'b0;
    expire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_step && is_access) begin
          if (is_legal) begin
            accept  = 1'b1;
            state_d = ST_REQ;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // Ack wins over an expiry landing on the same cycle.
        if (mem.i_mem_ack) begin
          ack_done = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          expire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_d;
  end

  // Load extraction: move the addressed lane down to bit 0, then extend.
  logic [NB-1:0] rd_shift;
  logic [NB-1:0] rd_ext;

  assign rd_shift = mem.i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    if (byte_q)
      rd_ext = {{(NB-8){signed_q & rd_shift[7]}}, rd_shift[7:0]};
    else if (half_q)
      rd_ext = {{(NB-16){signed_q & rd_shift[15]}}, rd_shift[15:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q       <= '0;
      off_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      byte_q       <= 1'b0;
      half_q       <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      access_err_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      access_err_q <= reject;
      timeout_q    <= expire;
      if (accept) begin
        addr_q   <= {i_alu_result[NB-1:2], 2'b00};
        off_q    <= i_alu_result[1:0];
        be_q     <= be_in;
        wdata_q  <= wdata_in;
        we_q     <= i_mem_write;
        signed_q <= i_signed;
        byte_q   <= is_byte;
        half_q   <= is_half;
        cnt_q    <= '0;
      end else if (state == ST_REQ && !mem.i_mem_ack) begin
        cnt_q <= cnt_q + NB_CNT'(1);
      end
      if (ack_done && !we_q) load_data_q <= rd_ext;
      if (expire)            load_data_q <= '0;
    end
  end

  assign mem.o_mem_req   = (state == ST_REQ);
  assign mem.o_mem_we    = (state == ST_REQ) & we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;
  assign mem.o_mem_be    = be_q;

  assign o_stall      = (state == ST_REQ);
  assign o_load_data  = load_data_q;
  assign o_load_valid = (state == ST_DONE) & ~we_q;
  assign o_access_err = access_err_q;
  assign o_timeout    = timeout_q;
  assign o_dbg_state  = state;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int NB         = 32;
  localparam int NB_TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset = 1'b1;
  logic          i_step = 1'b0;
  logic          i_mem_read = 1'b0;
  logic          i_mem_write = 1'b0;
  logic          i_signed = 1'b0;
  logic [2:0]    i_word_size = 3'b100;
  logic [NB-1:0] i_alu_result = '0;
  logic [NB-1:0] i_data_b = '0;
  logic          o_stall;
  logic [NB-1:0] o_load_data;
  logic          o_load_valid;
  logic          o_access_err;
  logic          o_timeout;
  logic [1:0]    o_dbg_state;

  mem_access_unit_if #(.NB(NB)) mem_if ();

  mem_access_unit #(.NB(NB), .NB_SIZE_TYPE(3), .NB_TIMEOUT(NB_TIMEOUT)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_step       (i_step),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_signed     (i_signed),
    .i_word_size  (i_word_size),
    .i_alu_result (i_alu_result),
    .i_data_b     (i_data_b),
    .mem          (mem_if),
    .o_stall      (o_stall),
    .o_load_data  (o_load_data),
    .o_load_valid (o_load_valid),
    .o_access_err (o_access_err),
    .o_timeout    (o_timeout),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [NB-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_legal(input logic rd, input logic wr, input logic [2:0] sz,
                                   input logic [NB-1:0] a);
    if (rd == wr) return 1'b0;
    case (sz)
      3'b001:  return 1'b1;
      3'b010:  return (a[0] == 1'b0);
      3'b100:  return (a[1:0] == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [NB-1:0] a);
    case (sz)
      3'b001:  return 4'b0001 << a[1:0];
      3'b010:  return 4'b0011 << (2 * a[1]);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [NB-1:0] m_wdata(input logic [2:0] sz, input logic [NB-1:0] d);
    case (sz)
      3'b001:  return {4{d[7:0]}};
      3'b010:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [NB-1:0] m_load(input logic [2:0] sz, input logic sgn,
                                           input logic [NB-1:0] a, input logic [NB-1:0] rdata);
    logic [NB-1:0] f;
    f = rdata >> (8 * a[1:0]);
    case (sz)
      3'b001:  return sgn ? {{24{f[7]}}, f[7:0]} : {24'h0, f[7:0]};
      3'b010:  return sgn ? {{16{f[15]}}, f[15:0]} : {16'h0, f[15:0]};
      default: return f;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (o_load_valid) begin
      if (exp_q.size() == 0) check_val("unexpected_load_valid", 1, 0);
      else                   check_val("load_data", o_load_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_garbage(input logic allow_step);
    i_step       = allow_step ? 1'($urandom_range(0, 1)) : 1'b0;
    i_mem_read   = 1'($urandom_range(0, 1));
    i_mem_write  = 1'($urandom_range(0, 1));
    i_signed     = 1'($urandom_range(0, 1));
    i_word_size  = 3'($urandom_range(0, 7));
    i_alu_result = $urandom;
    i_data_b     = $urandom;
    mem_if.i_mem_rdata = $urandom;
  endtask

  // ack_cyc: REQ cycle (1-based) in which ack is raised; 0 means never.
  task automatic do_access(input logic rd, input logic wr, input logic sgn, input logic [2:0] sz,
                           input logic [NB-1:0] addr, input logic [NB-1:0] data,
                           input logic [NB-1:0] rdata, input int ack_cyc);
    logic legal;
    logic acked;
    legal = m_legal(rd, wr, sz, addr);
    acked = 1'b0;
    @(negedge clk);
    i_step = 1'b1; i_mem_read = rd; i_mem_write = wr; i_signed = sgn;
    i_word_size = sz; i_alu_result = addr; i_data_b = data;
    @(negedge clk);
    if (!legal) begin
      drive_garbage(1'b0);
      check_val("access_err", NB'(o_access_err), NB'(rd | wr));
      check_val("err_no_req", NB'(mem_if.o_mem_req), 0);
      check_val("err_no_stall", NB'(o_stall), 0);
      check_val("err_state", NB'(o_dbg_state), 0);
      @(negedge clk);
      check_val("access_err_pulse", NB'(o_access_err), 0);
      return;
    end
    if (rd) exp_q.push_back(m_load(sz, sgn, addr, rdata));
    for (int cyc = 1; cyc <= NB_TIMEOUT; cyc++) begin
      if (cyc > 1) @(negedge clk);
      drive_garbage(1'b1);
      check_val("req", NB'(mem_if.o_mem_req), 1);
      check_val("stall", NB'(o_stall), 1);
      check_val("addr", mem_if.o_mem_addr, {addr[NB-1:2], 2'b00});
      check_val("be", NB'(mem_if.o_mem_be), NB'(m_be(sz, addr)));
      check_val("we", NB'(mem_if.o_mem_we), NB'(wr));
      check_val("wdata", mem_if.o_mem_wdata, m_wdata(sz, data));
      if (cyc == ack_cyc) begin
        mem_if.i_mem_ack = 1'b1;
        mem_if.i_mem_rdata = rdata;
        acked = 1'b1;
        break;
      end
    end
    @(negedge clk);
    i_step = 1'b0;
    // an ack here lands in DONE or IDLE and must be ignored
    mem_if.i_mem_ack = 1'($urandom_range(0, 1));
    mem_if.i_mem_rdata = $urandom;
    if (acked) begin
      check_val("done_state", NB'(o_dbg_state), 2);
      check_val("done_stall", NB'(o_stall), 0);
      check_val("done_req", NB'(mem_if.o_mem_req), 0);
      check_val("done_load_valid", NB'(o_load_valid), NB'(rd));
      check_val("done_timeout", NB'(o_timeout), 0);
    end else begin
      if (rd) void'(exp_q.pop_back());
      check_val("timeout", NB'(o_timeout), 1);
      check_val("to_req", NB'(mem_if.o_mem_req), 0);
      check_val("to_stall", NB'(o_stall), 0);
      check_val("to_load_data", o_load_data, 0);
      check_val("to_load_valid", NB'(o_load_valid), 0);
      check_val("to_state", NB'(o_dbg_state), 0);
    end
    @(negedge clk);
    mem_if.i_mem_ack = 1'b0;
    check_val("idle_state", NB'(o_dbg_state), 0);
    check_val("idle_load_valid", NB'(o_load_valid), 0);
    check_val("idle_timeout", NB'(o_timeout), 0);
    check_val("idle_req", NB'(mem_if.o_mem_req), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req"}, NB'(mem_if.o_mem_req), 0);
    check_val({tag, "_we"}, NB'(mem_if.o_mem_we), 0);
    check_val({tag, "_addr"}, mem_if.o_mem_addr, 0);
    check_val({tag, "_wdata"}, mem_if.o_mem_wdata, 0);
    check_val({tag, "_be"}, NB'(mem_if.o_mem_be), 0);
    check_val({tag, "_stall"}, NB'(o_stall), 0);
    check_val({tag, "_load_data"}, o_load_data, 0);
    check_val({tag, "_load_valid"}, NB'(o_load_valid), 0);
    check_val({tag, "_access_err"}, NB'(o_access_err), 0);
    check_val({tag, "_timeout"}, NB'(o_timeout), 0);
    check_val({tag, "_state"}, NB'(o_dbg_state), 0);
  endtask

  task automatic do_reset_mid_req();
    @(negedge clk);
    i_step = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_signed = 1'b0;
    i_word_size = 3'b100; i_alu_result = 32'h0000_0040; i_data_b = '0;
    @(negedge clk);
    i_step = 1'b0;
    check_val("rst_req_c1", NB'(mem_if.o_mem_req), 1);
    @(negedge clk);
    check_val("rst_req_c2", NB'(mem_if.o_mem_req), 1);
    i_reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    i_reset = 1'b0;
    mem_if.i_mem_ack = 1'b1;
    mem_if.i_mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_if.i_mem_ack = 1'b0;
    check_val("late_ack_load_valid", NB'(o_load_valid), 0);
    check_val("late_ack_req", NB'(mem_if.o_mem_req), 0);
    check_val("late_ack_state", NB'(o_dbg_state), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mem_if.i_mem_ack = 1'b0;
    mem_if.i_mem_rdata = '0;
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_reset = 1'b0;

    // signed byte load, lane 3
    do_access(1, 0, 1, 3'b001, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2);
    // unsigned half load, upper half
    do_access(1, 0, 0, 3'b010, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 1);
    // byte store, lane 1
    do_access(0, 1, 0, 3'b001, 32'h0000_0005, 32'h0000_00A5, 32'h0, 1);
    // signed half load, negative
    do_access(1, 0, 1, 3'b010, 32'h0000_0010, 32'h0, 32'h1234_8001, 3);
    // word store
    do_access(0, 1, 0, 3'b100, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 1);
    // illegal: misaligned word store, misaligned half, bad size, read+write
    do_access(0, 1, 0, 3'b100, 32'h0000_0006, 32'h1111_2222, 32'h0, 1);
    do_access(1, 0, 0, 3'b010, 32'h0000_0003, 32'h0, 32'h0, 1);
    do_access(1, 0, 0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1);
    do_access(1, 1, 0, 3'b001, 32'h0000_0000, 32'h0, 32'h0, 1);
    // timeout, then ack landing on the expiry cycle
    do_access(1, 0, 0, 3'b100, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 0);
    do_access(1, 0, 0, 3'b100, 32'h0000_0104, 32'h0, 32'h7654_3210, NB_TIMEOUT);
    // reset in the second REQ cycle with a late ack
    do_reset_mid_req();

    // random mix
    for (int n = 0; n < 30; n++) begin
      logic rd, wr;
      logic [2:0] sz;
      int pick;
      rd = 1'($urandom_range(0, 1));
      wr = ~rd;
      if ($urandom_range(0, 9) == 0) wr = rd;
      pick = $urandom_range(0, 9);
      sz = (pick < 3) ? 3'b001 : (pick < 6) ? 3'b010 : (pick < 9) ? 3'b100 : 3'b110;
      do_access(rd, wr, 1'($urandom_range(0, 1)), sz, $urandom, $urandom, $urandom,
                $urandom_range(1, 4));
    end

    repeat (2) @(negedge clk);
    check_val("exp_q_empty", NB'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: NB, default 32, datapath/address width; NB_SIZE_TYPE, default 3, word-size code width; NB_TIMEOUT, default 16, maximum cycles spent waiting for i_mem_ack.
REQ-002 i_clk  in  1  clock, all state updates on the rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_step  in  1  pipeline advance enable; new accesses are accepted only when high.
REQ-005 i_mem_read / i_mem_write  in  1 each  load / store request from the EX/MEM stage.
REQ-006 i_signed  in  1  load sign-extend (1) or zero-extend (0).
REQ-007 i_word_size  in  NB_SIZE_TYPE  3'b001 byte, 3'b010 half, 3'b100 word; other codes are illegal.
REQ-008 i_alu_result  in  NB  byte address; i_data_b  in  NB  store data.
REQ-009 o_mem_req, o_mem_we  out  1 each  memory request and write strobe.
REQ-010 o_mem_addr  out  NB  word-aligned address (bits [1:0] = 0); o_mem_wdata  out  NB; o_mem_be  out  4  byte enables.
REQ-011 i_mem_ack  in  1  memory completion; i_mem_rdata  in  NB  read word, valid while i_mem_ack is high.
REQ-012 o_stall  out  1  hold the pipeline; o_load_data  out  NB; o_load_valid, o_access_err, o_timeout  out  1 each  one-cycle pulses.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, and DONE.
REQ-014 IDLE -> REQ: on i_step=1 with exactly one of i_mem_read/i_mem_write high and a legal, aligned access; the address, size, signed flag, and store data are latched at this edge.
REQ-015 Input changes while in REQ or DONE SHALL be ignored.
REQ-016 Illegal access (both read and write high, illegal size code, half with addr[0]=1, word with addr[1:0]!=0) with i_step=1 SHALL pulse o_access_err for 1 cycle, issue no request, and remain in IDLE.
REQ-017 In REQ: o_mem_req=1, o_stall=1, and o_mem_addr/o_mem_we/o_mem_be/o_mem_wdata are held constant from the latched values.
REQ-018 Byte-lane mapping is little-endian. Byte: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}. Half: be=4'b0011<<(2*addr[1]), wdata={2{d[15:0]}}. Word: be=4'b1111, wdata=d.
REQ-019 On a loads, o_mem_be SHALL reflect the size and lane, and o_mem_we=0.
REQ-020 REQ -> DONE on i_mem_ack=1; o_mem_req drops at that edge. For loads, o_load_data is registered at that edge.
REQ-021 Load extraction: field = i_mem_rdata >> (8*addr[1:0]), truncated to 8 or 16 bits, or the full word for word loads; bit 7 or 15 is replicated when signed=1, otherwise the field is zero-filled.
REQ-022 In DONE: o_load_valid=1 for exactly 1 cycle on loads (0 on stores) and o_stall=0; DONE -> IDLE unconditionally.
REQ-023 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-024 When the counter reaches NB_TIMEOUT-1 without ack: o_timeout pulses 1 cycle, o_mem_req drops, o_load_data = 0, and the FSM goes to IDLE with no o_load_valid.
REQ-025 If ack and timeout expiry coincide, the ack SHALL win and normal completion applies.
REQ-026 i_mem_ack SHALL be ignored in IDLE and DONE.
REQ-027 o_stall SHALL be 0 in IDLE and DONE.
REQ-028 A new access is accepted only in IDLE; back-to-back accesses therefore take at least 3 cycles each (accept edge, REQ >= 1 cycle, DONE).

Reset
REQ-029 While i_reset=1 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL clear, and all outputs (o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_stall, o_load_data, o_load_valid, o_access_err, o_timeout) SHALL be 0.
REQ-030 Reset asserted mid-REQ SHALL drop o_mem_req at that edge; a late i_mem_ack after reset produces no o_load_valid.
REQ-031 i_reset SHALL take priority over i_step and i_mem_ack.

Verification
REQ-032 Signed byte load: addr=0x1003, rdata=0x80FF_1234, ack after 2 REQ cycles -> be=4'b1000, o_mem_addr=0x1000, o_load_data=0xFFFF_FF80, o_load_valid for 1 cycle, o_stall high for 2 cycles.
REQ-033 Unsigned half load: addr=0x0002, rdata=0x9ABC_0000 -> be=4'b1100, o_load_data=0x0000_9ABC.
REQ-034 Byte store: addr=0x0005, data_b=0x0000_00A5 -> o_mem_we=1, be=4'b0010, wdata=0xA5A5_A5A5, o_load_valid never asserted.
REQ-035 Misaligned word store: addr=0x0006 -> o_access_err pulse, o_mem_req stays 0, o_stall stays 0.
REQ-036 No ack with NB_TIMEOUT=16 -> o_timeout at REQ cycle 16, o_mem_req drops, o_load_data=0; a separate run with ack on that same cycle completes normally.
REQ-037 i_reset asserted in the 2nd REQ cycle, then ack one cycle later -> all outputs 0, state IDLE, no o_load_valid.
